// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
// -----------------------------------------------------------------------------
// Frame-level control for an 8x oversampled UART receiver. An external sampler
// majority-votes the line and presents the result on sampled_bit. That value is
// valid while edge_cnt==6. This block walks START -> DATA -> [PARITY] -> STOP
// and assembles the data word LSB first. At the end of each frame it reports
// exactly one outcome as a one-cycle pulse: a good word, a parity error and/or
// a stop error.
//
// Ports
//   Clk          : oversampling clock (8 cycles per bit), rising-edge active
//   Rst          : asynchronous, active-low reset
//   RX_IN_D      : synchronized serial line, idle high; only watched in IDLE
//   PAR_EN       : 1 = frame carries a parity bit (latched at frame start)
//   PAR_TYP      : 0 = even, 1 = odd parity (latched at frame start)
//   sampled_bit  : voted bit from the sampler, valid while edge_cnt==6
//   data_samp_en : sampler enable, high whenever a frame is in progress
//   edge_cnt     : oversampling phase counter driven to the sampler
//   P_DATA       : last error-free data word received
//   data_valid   : one-cycle pulse, P_DATA was just loaded with a new word
//   par_err      : one-cycle pulse, frame ended with a parity mismatch
//   stp_err      : one-cycle pulse, frame ended with the stop bit low
//   busy         : high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RX_IN_D,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [2:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  // Width of the data bit counter; it never needs to exceed DATA_WIDTH-1.
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  // Oversampling phases of interest within one bit period.
  localparam logic [2:0] SAMPLE_PHASE = 3'd6;
  localparam logic [2:0] BOUND_PHASE  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q,      state_d;
  logic [2:0]              edge_cnt_q,   edge_cnt_d;
  logic [BCW-1:0]          bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
  logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q,    par_err_d;
  logic                    stp_err_q,    stp_err_d;
  logic                    par_en_q,     par_en_d;
  logic                    par_typ_q,    par_typ_d;
  logic                    par_flag_q,   par_flag_d;
  logic                    stp_flag_q,   stp_flag_d;

  // All state lives here. Reset abandons any frame in flight without a pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_flag_q   <= par_flag_d;
      stp_flag_q   <= stp_flag_d;
    end
  end

  // Next-state and frame bookkeeping. Bit boundaries fall on the edge where
  // edge_cnt==7. The sampler result is consumed on the edge where edge_cnt==6.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_flag_d   = par_flag_q;
    stp_flag_d   = stp_flag_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    // The phase counter free-runs during a frame and wraps 7->0 by overflow.
    if (state_q == IDLE) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        // Parity settings are frozen here, so mid-frame changes are ignored.
        if (!RX_IN_D) begin
          state_d    = START;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end
      end

      START: begin
        // A start bit that votes high mid-bit was only a glitch.
        if (edge_cnt_q == SAMPLE_PHASE && sampled_bit) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (edge_cnt_q == BOUND_PHASE) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (edge_cnt_q == SAMPLE_PHASE) begin
          shift_d[bit_cnt_q] = sampled_bit;
        end
        if (edge_cnt_q == BOUND_PHASE) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        // Even parity expects ^data; odd expects its inverse, hence the
        // extra XOR with the latched parity type.
        if (edge_cnt_q == SAMPLE_PHASE) begin
          par_flag_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
        end
        if (edge_cnt_q == BOUND_PHASE) begin
          state_d = STOP;
        end
      end

      STOP: begin
        if (edge_cnt_q == SAMPLE_PHASE) begin
          stp_flag_d = ~sampled_bit;
        end
        // A word is published only when the frame was clean. Otherwise the
        // error pulses fire and P_DATA keeps the previous good word.
        if (edge_cnt_q == BOUND_PHASE) begin
          state_d = IDLE;
          if (!par_flag_q && !stp_flag_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end else begin
            par_err_d = par_flag_q;
            stp_err_d = stp_flag_q;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign data_samp_en = (state_q != IDLE);
  assign edge_cnt     = edge_cnt_q;
  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm
// -----------------------------------------------------------------------------
// This bench checks uart_rx_fsm using directed frames followed by randomized
// frames. The bench plays the role of the line and of the sampler: each bit
// level is held for 8 clocks. The outcome of every frame comes from the
// serial-frame rules: count the ones for parity and look at the stop bit.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       RX_IN_D = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       sampled_bit = 1'b1;
   logic       data_samp_en;
   logic [2:0] edge_cnt;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       busy;

   int testCount = 0;
   int failCount = 0;

   // The last good word the receiver should be presenting.
   logic [7:0] expData = 8'h00;

   uart_rx_fsm #(.DATA_WIDTH(8)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .RX_IN_D(RX_IN_D),
      .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP),
      .sampled_bit(sampled_bit),
      .data_samp_en(data_samp_en),
      .edge_cnt(edge_cnt),
      .P_DATA(P_DATA),
      .data_valid(data_valid),
      .par_err(par_err),
      .stp_err(stp_err),
      .busy(busy)
   );

   // 10 ns oversampling clock
   always #5 Clk = ~Clk;

   // This guard stops the run if it ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison in the bench goes through this task.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // The bench samples and drives 1 ns after each rising edge.
   task automatic stepCycle();
      @(posedge Clk);
      #1;
   endtask

   // This is the expected picture of an idle receiver with no pulse pending.
   task automatic checkQuiet(input string where);
      checkOutput({where, ".busy"}, busy, 0);
      checkOutput({where, ".samp_en"}, data_samp_en, 0);
      checkOutput({where, ".edge_cnt"}, edge_cnt, 0);
      checkOutput({where, ".pulses"}, {data_valid, par_err, stp_err}, 0);
      checkOutput({where, ".P_DATA"}, P_DATA, expData);
   endtask

   task automatic idleCycles(input int k);
      RX_IN_D = 1'b1;
      sampled_bit = 1'b1;
      repeat (k) begin
         stepCycle();
         checkQuiet("idle");
      end
   endtask

   // This task sends one frame and then checks the outcome pulse in the first
   // IDLE cycle. When noise is set, the raw line is scrambled after the start
   // edge and the parity inputs are flipped mid-frame; neither should matter.
   // When abortAt is nonzero, reset is pulsed after that many clocks.
   task automatic applyStimulus(input logic [7:0] data, input bit pe, input bit pt,
                                input bit parBit, input bit stopBit, input bit noise,
                                input int abortAt);
      logic bits[$];
      int   nb;
      int   ones;
      bit   expPar, expStp, expValid;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (pe) bits.push_back(parBit);
      bits.push_back(stopBit);
      nb = bits.size();
      PAR_EN = pe;
      PAR_TYP = pt;
      for (int n = 0; n < nb * 8; n++) begin
         sampled_bit = bits[n / 8];
         RX_IN_D = (noise && n > 0) ? 1'($urandom_range(0, 1)) : bits[n / 8];
         stepCycle();
         if (noise && n == 0) begin
            PAR_EN = ~pe;
            PAR_TYP = ~pt;
         end
         checkOutput("frame.busy", busy, 1);
         checkOutput("frame.samp_en", data_samp_en, 1);
         checkOutput("frame.edge_cnt", edge_cnt, n % 8);
         checkOutput("frame.pulses", {data_valid, par_err, stp_err}, 0);
         checkOutput("frame.P_DATA", P_DATA, expData);
         if (abortAt == n + 1) begin
            Rst = 1'b0;
            #1;
            expData = 8'h00;
            checkQuiet("reset");
            stepCycle();
            checkQuiet("reset.hold");
            RX_IN_D = 1'b1;
            sampled_bit = 1'b1;
            PAR_EN = 1'b0;
            Rst = 1'b1;
            stepCycle();
            checkQuiet("reset.release");
            return;
         end
      end
      RX_IN_D = 1'b1;
      sampled_bit = 1'b1;
      stepCycle();
      ones = $countones(data) + int'(parBit);
      expPar = pe && ((ones % 2) != int'(pt));
      expStp = !stopBit;
      expValid = !expPar && !expStp;
      if (expValid) expData = data;
      checkOutput("end.data_valid", data_valid, expValid);
      checkOutput("end.par_err", par_err, expPar);
      checkOutput("end.stp_err", stp_err, expStp);
      checkOutput("end.P_DATA", P_DATA, expData);
      checkOutput("end.busy", busy, 0);
      checkOutput("end.edge_cnt", edge_cnt, 0);
   endtask

   // In this case the start bit drops for two clocks and the sampler then
   // votes high, so the frame should be rejected.
   task automatic applyGlitch();
      RX_IN_D = 1'b0;
      sampled_bit = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         stepCycle();
         if (n == 2) RX_IN_D = 1'b1;
         checkOutput("glitch.busy", busy, 1);
         checkOutput("glitch.edge_cnt", edge_cnt, n - 1);
         checkOutput("glitch.pulses", {data_valid, par_err, stp_err}, 0);
      end
      stepCycle();
      checkQuiet("glitch.end");
      idleCycles(3);
   endtask

   initial begin
      stepCycle();
      checkQuiet("por");
      stepCycle();
      Rst = 1'b1;
      idleCycles(2);

      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idleCycles(1);
      applyStimulus(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idleCycles(1);
      applyStimulus(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      idleCycles(1);
      applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      idleCycles(1);
      applyGlitch();

      // These two frames are back to back: the second start bit falls in the
      // first IDLE cycle.
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idleCycles(2);

      // Reset arrives mid data bit 4 of 0xFF, then a clean 0x12 follows.
      applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 44);
      idleCycles(2);
      applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idleCycles(1);

      for (int f = 0; f < 40; f++) begin
         applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), 0);
         idleCycles(int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
